// File: rtl/dmem_sram_responder.sv
// dmem_sram_responder
//   Data-memory responder that serves 32-bit core accesses from an external
//   8-bit asynchronous SRAM, one byte lane per phase, big-endian (lane 0 is
//   bits 31:24 and SRAM byte address +0).
//   Optional feature macro: DMEM_SKIP_LANES_EN -- writes visit only the lanes
//   whose byte enable is set; reads always visit all four lanes.
module dmem_sram_responder #(
  parameter int AW       = 20,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   Zz_addr,
  input  logic [31:0]   Zz_dout,
  input  logic [3:0]    Zz_wr_en,
  input  logic          rd_en,
  output logic [31:0]   zZ_din,
  output logic          pause,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dq_o,
  input  logic [7:0]    sram_dq_i
);

  localparam int              PW      = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
  localparam logic [PW-1:0]   PH_LAST = PW'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LANE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_r, state_n;
  logic [1:0]    lane_r, lane_n;
  logic [PW-1:0] ph_r, ph_n;
  logic          wr_mode_r, wr_mode_n;
  logic [31:0]   asm_r;
  logic [31:0]   rdata_r;

  logic          req;
  logic          write;
  logic          cur_write;
  logic [3:0]    lane_mask;
  logic [2:0]    first_lane;
  logic [2:0]    next_lane;
  logic          last_phase;

  // Lowest lane index >= from whose mask bit is set; 3'd4 means none left.
  // Lane l is governed by mask bit 3-l (lane 0 is the MSB byte).
  function automatic logic [2:0] scan_lane(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && mask[3-i]) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction

  // Byte of a big-endian word that belongs to a lane.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    logic [7:0] b;
    case (l)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign req        = (rd_en | (|Zz_wr_en)) & ~Zz_addr[31];
  assign write      = |Zz_wr_en;
  assign last_phase = (ph_r == PH_LAST);
  // While an access runs, the latched mode decides; in IDLE the live request does.
  assign cur_write  = (state_r == S_IDLE) ? write : wr_mode_r;

`ifdef DMEM_SKIP_LANES_EN
  assign lane_mask  = cur_write ? Zz_wr_en : 4'b1111;
`else
  assign lane_mask  = 4'b1111;
`endif

  assign first_lane = scan_lane(lane_mask, 3'd0);
  assign next_lane  = scan_lane(lane_mask, {1'b0, lane_r} + 3'd1);

  // State register: FSM state, lane/phase counters and access mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      lane_r    <= 2'd0;
      ph_r      <= '0;
      wr_mode_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      lane_r    <= lane_n;
      ph_r      <= ph_n;
      wr_mode_r <= wr_mode_n;
    end
  end

  // Next-state logic: walk the lanes phase by phase, then one DONE cycle.
  always_comb begin
    state_n   = state_r;
    lane_n    = lane_r;
    ph_n      = ph_r;
    wr_mode_n = wr_mode_r;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          state_n   = S_LANE;
          lane_n    = first_lane[1:0];
          ph_n      = '0;
          wr_mode_n = write;
        end else begin
          state_n   = S_IDLE;
        end
      end
      S_LANE: begin
        if (!last_phase) begin
          ph_n = ph_r + PW'(1);
        end else if (next_lane[2]) begin
          state_n = S_DONE;
          lane_n  = 2'd0;
          ph_n    = '0;
        end else begin
          lane_n  = next_lane[1:0];
          ph_n    = '0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        lane_n  = 2'd0;
        ph_n    = '0;
      end
    endcase
  end

  // Output decode: stall request and SRAM strobes from the current state.
  always_comb begin
    pause     = 1'b0;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_addr = '0;
    sram_dq_o = 8'h00;
    case (state_r)
      S_IDLE: begin
        pause = req;
      end
      S_LANE: begin
        pause     = 1'b1;
        sram_ce_n = 1'b0;
        sram_addr = {Zz_addr[AW-1:2], lane_r};
        if (wr_mode_r) begin
          sram_oe_n = 1'b1;
          sram_dq_o = lane_byte(Zz_dout, lane_r);
          sram_we_n = ~(last_phase & Zz_wr_en[~lane_r]);
        end else begin
          sram_oe_n = 1'b0;
          sram_we_n = 1'b1;
        end
      end
      S_DONE: begin
        pause = 1'b0;
      end
      default: begin
        pause = 1'b0;
      end
    endcase
  end

  // Read datapath: capture each byte at the end of its phase, publish after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r   <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
    end else begin
      if ((state_r == S_LANE) && !wr_mode_r && last_phase) begin
        case (lane_r)
          2'd0:    asm_r[31:24] <= sram_dq_i;
          2'd1:    asm_r[23:16] <= sram_dq_i;
          2'd2:    asm_r[15:8]  <= sram_dq_i;
          2'd3:    asm_r[7:0]   <= sram_dq_i;
          default: asm_r        <= asm_r;
        endcase
      end
      if ((state_r == S_DONE) && !wr_mode_r) begin
        rdata_r <= asm_r;
      end
    end
  end

  assign zZ_din = rdata_r;

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: table of core accesses against a byte-wide
// SRAM model, read data checked through a scoreboard queue, plus a
// reset-during-write sequence. Honours DMEM_SKIP_LANES_EN for expectations.
module tb_dmem_sram_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] Zz_addr;
  logic [31:0] Zz_dout;
  logic [3:0]  Zz_wr_en;
  logic        rd_en;
  logic [31:0] zZ_din;
  logic        pause;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [19:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic [7:0]  sram_dq_i;

  dmem_sram_responder #(.AW(20), .WAIT_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Zz_addr   (Zz_addr),
    .Zz_dout   (Zz_dout),
    .Zz_wr_en  (Zz_wr_en),
    .rd_en     (rd_en),
    .zZ_din    (zZ_din),
    .pause     (pause),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_i (sram_dq_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 1 KiB, write on a clock edge with ce_n and we_n low.
  logic [7:0] mem [0:1023];
  int wr_cnt;
  int ce_cnt;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 8'h00;

  always @(posedge clk) begin
    if (!sram_ce_n) ce_cnt <= ce_cnt + 1;
    if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[9:0]] <= sram_dq_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    logic [3:0]  wr_en;
    logic        rd_en;
    int          exp_pause;
    int          exp_wr;
    logic        is_read;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] sb_q[$];
  logic [31:0] last_word;

  // Drive one access at a negedge; count pause cycles until release.
  task automatic do_access(input vec_t v, input int idx);
    int pc;
    int wr0;
    int ce0;
    logic [31:0] exp_w;
    pc  = 0;
    wr0 = wr_cnt;
    ce0 = ce_cnt;
    if (v.is_read) sb_q.push_back(v.exp_word);
    Zz_addr  = v.addr;
    Zz_dout  = v.dout;
    Zz_wr_en = v.wr_en;
    rd_en    = v.rd_en;
    #1;
    while (pause && pc < 100) begin
      pc++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    Zz_wr_en = 4'b0000;
    rd_en    = 1'b0;
    #1;
    chk($sformatf("pause_cycles[%0d]", idx), 32'(pc), 32'(v.exp_pause));
    chk($sformatf("sram_writes[%0d]", idx), 32'(wr_cnt - wr0), 32'(v.exp_wr));
    chk($sformatf("ce_cycles[%0d]", idx), 32'(ce_cnt - ce0),
        32'((v.exp_pause > 0) ? v.exp_pause - 1 : 0));
    if (sb_q.size() > 0) begin
      exp_w     = sb_q.pop_front();
      last_word = exp_w;
    end else begin
      exp_w = last_word;
    end
    chk($sformatf("zZ_din[%0d]", idx), zZ_din, exp_w);
  endtask

  int p_sb;
  int p_half;
  int wr_snap;

  initial begin
    checks    = 0;
    errors    = 0;
    wr_cnt    = 0;
    ce_cnt    = 0;
    last_word = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
`ifdef DMEM_SKIP_LANES_EN
    p_sb   = 3;
    p_half = 5;
`else
    p_sb   = 9;
    p_half = 9;
`endif
    //        addr          dout          wr_en    rd    pause   wr  read   word
    vecs[0] = '{32'h0000_0100, 32'h1122_3344, 4'b1111, 1'b0, 9,      4,  1'b0, 32'h0};
    vecs[1] = '{32'h0000_0100, 32'h0000_0000, 4'b0000, 1'b1, 9,      0,  1'b1, 32'h1122_3344};
    vecs[2] = '{32'h0000_0102, 32'hABAB_ABAB, 4'b0010, 1'b0, p_sb,   1,  1'b0, 32'h0};
    vecs[3] = '{32'h0000_0100, 32'h0000_0000, 4'b0000, 1'b1, 9,      0,  1'b1, 32'h1122_AB44};
    vecs[4] = '{32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b1, 0,      0,  1'b0, 32'h0};
    vecs[5] = '{32'h0000_0200, 32'hCAFE_BEEF, 4'b1100, 1'b1, p_half, 2,  1'b0, 32'h0};
    vecs[6] = '{32'h0000_0200, 32'h0000_0000, 4'b0000, 1'b1, 9,      0,  1'b1, 32'hCAFE_0000};
    vecs[7] = '{32'h8000_0004, 32'hFFFF_FFFF, 4'b1111, 1'b0, 0,      0,  1'b0, 32'h0};

    rst_n    = 1'b0;
    Zz_addr  = 32'h0;
    Zz_dout  = 32'h0;
    Zz_wr_en = 4'b0000;
    rd_en    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pause", {31'h0, pause}, 32'h0);
    chk("rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
    chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rst_addr", {12'h0, sram_addr}, 32'h0);
    chk("rst_dq_o", {24'h0, sram_dq_o}, 32'h0);
    chk("rst_zz_din", zZ_din, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i], i);
    end

    chk("mem_100", {24'h0, mem[10'h100]}, 32'h11);
    chk("mem_101", {24'h0, mem[10'h101]}, 32'h22);
    chk("mem_102", {24'h0, mem[10'h102]}, 32'hAB);
    chk("mem_103", {24'h0, mem[10'h103]}, 32'h44);
    chk("mem_200", {24'h0, mem[10'h200]}, 32'hCA);
    chk("mem_201", {24'h0, mem[10'h201]}, 32'hFE);
    chk("mem_202", {24'h0, mem[10'h202]}, 32'h00);
    chk("mem_203", {24'h0, mem[10'h203]}, 32'h00);

    // Reset in the middle of a word write.
    Zz_addr  = 32'h0000_0300;
    Zz_dout  = 32'h5566_7788;
    Zz_wr_en = 4'b1111;
    rd_en    = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_pause_busy", {31'h0, pause}, 32'h1);
    rst_n    = 1'b0;
    Zz_wr_en = 4'b0000;
    wr_snap  = wr_cnt;
    #1;
    chk("mid_rst_pause", {31'h0, pause}, 32'h0);
    chk("mid_rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("mid_rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("mid_rst_zz_din", zZ_din, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("post_rst_writes", 32'(wr_cnt - wr_snap), 32'h0);
    chk("post_rst_pause", {31'h0, pause}, 32'h0);
    chk("post_rst_mem_303", {24'h0, mem[10'h303]}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
